// File: rtl/bcd_score_tracker.sv
// Packed-BCD game score counter with tick/bonus increments, milestone and
// overflow pulses, and a high-score register committed on game_over.
module bcd_score_tracker #(
    parameter int DIGITS          = 5,
    parameter int WRAP            = 1,
    parameter int MILESTONE_DIGIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_start,
    input  logic                  game_frozen,
    input  logic                  game_tick,
    input  logic                  bonus_valid,
    input  logic [3:0]            bonus_amt,
    input  logic                  game_over,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   high_score,
    output logic                  new_high,
    output logic                  milestone,
    output logic                  overflow
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned MW = 4 * MILESTONE_DIGIT;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [3:0]   amt;
    logic [3:0]   inc;
    logic [4:0]   acc;
    logic         carry;
    logic [W-1:0] sum;
    logic [W-1:0] nxt;
    logic         ms_hit;

    // Increment for this cycle: tick plus clamped bonus, suppressed by control inputs.
    always_comb begin
        amt = (bonus_amt > 4'd9) ? 4'd9 : bonus_amt;
        inc = 4'(game_tick) + (bonus_valid ? amt : 4'd0);
        if (game_frozen || game_start || game_over) begin
            inc = 4'd0;
        end
    end

    // Single-cycle ripple BCD adder; inc only enters digit 0, carry ripples upward.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        acc   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            acc = {1'b0, score[4*i +: 4]} + ((i == 0) ? {1'b0, inc} : 5'd0) + {4'd0, carry};
            if (acc >= 5'd10) begin
                sum[4*i +: 4] = 4'(acc - 5'd10);
                carry         = 1'b1;
            end else begin
                sum[4*i +: 4] = acc[3:0];
                carry         = 1'b0;
            end
        end
    end

    // Carry out of the top digit means the sum reached 10^DIGITS.
    always_comb begin
        nxt    = (carry && (WRAP == 0)) ? ALL_NINES : sum;
        ms_hit = (inc != 4'd0) && (nxt[W-1:MW] != score[W-1:MW]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score      <= '0;
            high_score <= '0;
            new_high   <= 1'b0;
            milestone  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            milestone <= 1'b0;
            overflow  <= 1'b0;
            // Commit uses the pre-cycle score, even when game_start clears it this cycle.
            if (game_over) begin
                if (score > high_score) begin
                    high_score <= score;
                    new_high   <= 1'b1;
                end else begin
                    new_high   <= 1'b0;
                end
            end
            if (game_start) begin
                score    <= '0;
                new_high <= 1'b0;
            end else if (inc != 4'd0) begin
                score     <= nxt;
                overflow  <= carry;
                milestone <= ms_hit;
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_tracker.sv
// Directed bench for bcd_score_tracker: one wrapping and one saturating instance share stimulus.
module tb_bcd_score_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_start;
    logic        game_frozen;
    logic        game_tick;
    logic        bonus_valid;
    logic [3:0]  bonus_amt;
    logic        game_over;

    logic [19:0] score_w, high_w, score_s, high_s;
    logic        nh_w, ms_w, ov_w, nh_s, ms_s, ov_s;

    int checks = 0;
    int errors = 0;
    logic ms_seen, ov_seen;

    always #5 clk = ~clk;

    bcd_score_tracker #(.DIGITS(5), .WRAP(1), .MILESTONE_DIGIT(2)) u_wrap (
        .clk(clk), .rst(rst), .game_start(game_start), .game_frozen(game_frozen),
        .game_tick(game_tick), .bonus_valid(bonus_valid), .bonus_amt(bonus_amt),
        .game_over(game_over), .score(score_w), .high_score(high_w),
        .new_high(nh_w), .milestone(ms_w), .overflow(ov_w)
    );

    bcd_score_tracker #(.DIGITS(5), .WRAP(0), .MILESTONE_DIGIT(2)) u_sat (
        .clk(clk), .rst(rst), .game_start(game_start), .game_frozen(game_frozen),
        .game_tick(game_tick), .bonus_valid(bonus_valid), .bonus_amt(bonus_amt),
        .game_over(game_over), .score(score_s), .high_score(high_s),
        .new_high(nh_s), .milestone(ms_s), .overflow(ov_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of pulse inputs, then sample #1 after the edge.
    task automatic drive(input logic tk, input logic bv, input logic [3:0] amt);
        game_tick   = tk;
        bonus_valid = bv;
        bonus_amt   = amt;
        @(posedge clk);
        #1;
        game_tick   = 1'b0;
        bonus_valid = 1'b0;
        bonus_amt   = 4'd0;
        game_start  = 1'b0;
        game_over   = 1'b0;
    endtask

    // Add n*10 points using tick + bonus 9 each cycle.
    task automatic add_tens(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 4'd9);
    endtask

    initial begin
        rst = 1'b1; game_start = 1'b0; game_frozen = 1'b0; game_tick = 1'b0;
        bonus_valid = 1'b0; bonus_amt = 4'd0; game_over = 1'b0;

        // Reset overrides a concurrent tick.
        drive(1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 4'd9);
        check("rst_score", 32'(score_w), 32'h0);
        check("rst_high", 32'(high_w), 32'h0);
        check("rst_new_high", 32'(nh_w), 32'h0);
        check("rst_milestone", 32'(ms_w), 32'h0);
        check("rst_overflow", 32'(ov_w), 32'h0);
        rst = 1'b0;

        // 12 ticks.
        ms_seen = 1'b0; ov_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 4'd0);
            ms_seen |= ms_w; ov_seen |= ov_w;
        end
        check("ticks12_score", 32'(score_w), 32'h00012);
        check("ticks12_no_ms", 32'(ms_seen), 32'h0);
        check("ticks12_no_ov", 32'(ov_seen), 32'h0);

        // 12 + 9*9 + 5 = 98, then tick + 9 -> 108.
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 4'd9);
        drive(1'b0, 1'b1, 4'd5);
        check("to98_score", 32'(score_w), 32'h00098);
        drive(1'b1, 1'b1, 4'd9);
        check("s108_score", 32'(score_w), 32'h00108);
        check("s108_ms", 32'(ms_w), 32'h1);
        check("s108_ov", 32'(ov_w), 32'h0);
        drive(1'b0, 1'b0, 4'd0);
        check("idle_ms_clear", 32'(ms_w), 32'h0);

        // Frozen suppresses everything; unfrozen bonus 15 clamps to 9.
        game_frozen = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 4'd15);
        check("frozen_score", 32'(score_w), 32'h00108);
        game_frozen = 1'b0;
        drive(1'b0, 1'b1, 4'd15);
        check("clamp_score", 32'(score_w), 32'h00117);
        check("clamp_ms", 32'(ms_w), 32'h0);

        // 117 + 130 + 3 = 250, commit as new high.
        add_tens(13);
        drive(1'b1, 1'b1, 4'd2);
        check("to250_score", 32'(score_w), 32'h00250);
        game_over = 1'b1;
        drive(1'b1, 1'b0, 4'd0);
        check("go250_high", 32'(high_w), 32'h00250);
        check("go250_new_high", 32'(nh_w), 32'h1);
        check("go250_score_held", 32'(score_w), 32'h00250);
        drive(1'b1, 1'b0, 4'd0);
        check("new_high_holds", 32'(nh_w), 32'h1);

        // New game of 100 ticks does not beat 250.
        game_start = 1'b1;
        drive(1'b1, 1'b0, 4'd0);
        check("start_score", 32'(score_w), 32'h0);
        check("start_new_high", 32'(nh_w), 32'h0);
        check("start_high_kept", 32'(high_w), 32'h00250);
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 4'd0);
        check("ticks100_score", 32'(score_w), 32'h00100);
        game_over = 1'b1;
        drive(1'b0, 1'b0, 4'd0);
        check("go100_high", 32'(high_w), 32'h00250);
        check("go100_new_high", 32'(nh_w), 32'h0);

        // Simultaneous start + over with 300 > 250.
        game_start = 1'b1;
        drive(1'b0, 1'b0, 4'd0);
        add_tens(30);
        check("to300_score", 32'(score_w), 32'h00300);
        game_start = 1'b1; game_over = 1'b1;
        drive(1'b1, 1'b0, 4'd0);
        check("both_high", 32'(high_w), 32'h00300);
        check("both_score", 32'(score_w), 32'h0);
        check("both_new_high", 32'(nh_w), 32'h0);

        // Climb to 99998 on both instances.
        ov_seen = 1'b0;
        for (int i = 0; i < 9999; i++) begin
            drive(1'b1, 1'b1, 4'd9);
            ov_seen |= ov_w | ov_s;
        end
        drive(1'b0, 1'b1, 4'd8);
        check("top_wrap_score", 32'(score_w), 32'h99998);
        check("top_sat_score", 32'(score_s), 32'h99998);
        check("top_no_ov", 32'(ov_seen), 32'h0);
        drive(1'b0, 1'b1, 4'd5);
        check("wrap_score", 32'(score_w), 32'h00003);
        check("wrap_ov", 32'(ov_w), 32'h1);
        check("wrap_ms", 32'(ms_w), 32'h1);
        check("sat_score", 32'(score_s), 32'h99999);
        check("sat_ov", 32'(ov_s), 32'h1);
        check("sat_ms", 32'(ms_s), 32'h0);
        drive(1'b1, 1'b0, 4'd0);
        check("wrap_next_score", 32'(score_w), 32'h00004);
        check("wrap_next_ov", 32'(ov_w), 32'h0);
        check("sat_again_score", 32'(score_s), 32'h99999);
        check("sat_again_ov", 32'(ov_s), 32'h1);
        check("sat_again_ms", 32'(ms_s), 32'h0);

        // Mid-game reset discards score and high score; first edge after release counts.
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'd0);
        check("midrst_score", 32'(score_w), 32'h0);
        check("midrst_high", 32'(high_w), 32'h0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'd0);
        check("post_rst_tick", 32'(score_w), 32'h00001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
